coco_ram_scheduler: RTL

- Time-slot scheduler that shares the single 64K x 8 system RAM between three requesters: the 6809 CPU, the VDG display fetch and the ioctl cartridge/RAM loader.
- Divides each E cycle into 16 slots of the 14.318 MHz enable.
- Grants fixed slots to CPU and video, and gives every other slot to a buffered loader write queue.
- Sits between the SAM/CPU bus and the RAM macro, replacing ad-hoc dual-port sharing.

---
 rtl/coco_mem_pkg.sv | 13 +
 rtl/coco_ram_scheduler_if.sv | 36 +++
 rtl/coco_wr_fifo.sv | 48 ++++
 rtl/coco_ram_scheduler.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/coco_mem_pkg.sv
// Shared constants and types for the CoCo system RAM time-slot scheduler.
package coco_mem_pkg;
    localparam int SLOT_W       = 4;
    localparam int NUM_SLOTS    = 16;
    localparam int CPU_SLOT_DEF = 8;
    localparam int VID_SLOT_DEF = 0;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CPU  = 2'd1,
        RD_VID  = 2'd2
    } rd_tag_e;
endpackage

// File: rtl/coco_ram_scheduler_if.sv
// Requester and RAM-macro signals of the slot scheduler, bundled for one port.
interface coco_ram_scheduler_if #(
    parameter int ADDR_W = 16
);
    logic              cpu_cs;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              cpu_rvalid;
    logic [ADDR_W-1:0] vid_addr;
    logic [7:0]        vid_data;
    logic              vid_valid;
    logic              ldr_wr;
    logic [ADDR_W-1:0] ldr_addr;
    logic [7:0]        ldr_data;
    logic              ldr_ready;
    logic              ldr_overflow;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_din;
    logic              ram_we;
    logic              ram_en;
    logic [7:0]        ram_dout;

    modport slave (
        input  cpu_cs, cpu_we, cpu_addr, cpu_wdata, vid_addr, ldr_wr, ldr_addr, ldr_data, ram_dout,
        output cpu_rdata, cpu_rvalid, vid_data, vid_valid, ldr_ready, ldr_overflow,
        output ram_addr, ram_din, ram_we, ram_en
    );

    modport master (
        output cpu_cs, cpu_we, cpu_addr, cpu_wdata, vid_addr, ldr_wr, ldr_addr, ldr_data, ram_dout,
        input  cpu_rdata, cpu_rvalid, vid_data, vid_valid, ldr_ready, ldr_overflow,
        input  ram_addr, ram_din, ram_we, ram_en
    );
endinterface

// File: rtl/coco_wr_fifo.sv
// Synchronous FIFO holding buffered loader writes ({addr, data}) until a free slot.
module coco_wr_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    // A pop frees the head this cycle, so a push into a full queue still lands.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{PTR_W{1'b0}}, w_do_push} - {{PTR_W{1'b0}}, w_do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end
endmodule

// File: rtl/coco_ram_scheduler.sv
// Shares one 64Kx8 RAM between CPU, VDG fetch and loader using 16 fixed slots per E cycle.
module coco_ram_scheduler
    import coco_mem_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int CPU_SLOT   = CPU_SLOT_DEF,
    parameter int VID_SLOT   = VID_SLOT_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_ena,
    input  logic               e,
    coco_ram_scheduler_if.slave bus
);
    generate
        if (CPU_SLOT == VID_SLOT) begin : g_bad_slots
            $error("coco_ram_scheduler: CPU_SLOT and VID_SLOT must differ");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("coco_ram_scheduler: FIFO_DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    logic [SLOT_W-1:0]          r_slot;
    logic                       r_e_prev;
    logic                       r_ram_en;
    logic                       r_ram_we;
    logic [ADDR_W-1:0]          r_ram_addr;
    logic [7:0]                 r_ram_din;
    rd_tag_e                    r_tag;
    logic                       r_cpu_rvalid;
    logic                       r_vid_valid;
    logic [7:0]                 r_cpu_rdata;
    logic [7:0]                 r_vid_data;
    logic                       r_overflow;

    logic                       w_issue;
    logic                       w_we;
    logic [ADDR_W-1:0]          w_addr;
    logic [7:0]                 w_din;
    rd_tag_e                    w_tag;
    logic                       w_pop;
    logic [ADDR_W+7:0]          w_head;
    logic                       w_full;
    logic                       w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    coco_wr_fifo #(
        .WIDTH (ADDR_W + 8),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (bus.ldr_wr),
        .i_wdata ({bus.ldr_addr, bus.ldr_data}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // The tick that sees E rise is slot 0, so the counter reloads to 1 for the next tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_slot   <= '0;
            r_e_prev <= 1'b0;
        end else if (clk_ena) begin
            r_e_prev <= e;
            r_slot   <= (e && !r_e_prev) ? SLOT_W'(1) : r_slot + 1'b1;
        end
    end

    always_comb begin
        w_issue = 1'b0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_din   = '0;
        w_tag   = RD_NONE;
        w_pop   = 1'b0;
        if (clk_ena) begin
            if (r_slot == SLOT_W'(VID_SLOT)) begin
                w_issue = 1'b1;
                w_addr  = bus.vid_addr;
                w_tag   = RD_VID;
            end else if (r_slot == SLOT_W'(CPU_SLOT)) begin
                // An unused CPU slot stays idle so CPU timing never depends on loader traffic.
                if (bus.cpu_cs) begin
                    w_issue = 1'b1;
                    w_we    = bus.cpu_we;
                    w_addr  = bus.cpu_addr;
                    w_din   = bus.cpu_wdata;
                    w_tag   = bus.cpu_we ? RD_NONE : RD_CPU;
                end
            end else if (!w_empty) begin
                w_issue = 1'b1;
                w_we    = 1'b1;
                w_addr  = w_head[ADDR_W+7:8];
                w_din   = w_head[7:0];
                w_pop   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
            r_tag        <= RD_NONE;
            r_cpu_rvalid <= 1'b0;
            r_vid_valid  <= 1'b0;
            r_cpu_rdata  <= '0;
            r_vid_data   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_ram_en     <= w_issue;
            r_ram_we     <= w_we;
            r_tag        <= w_tag;
            if (w_issue) begin
                r_ram_addr <= w_addr;
                r_ram_din  <= w_din;
            end
            r_cpu_rvalid <= (r_tag == RD_CPU);
            r_vid_valid  <= (r_tag == RD_VID);
            if (r_cpu_rvalid) r_cpu_rdata <= bus.ram_dout;
            if (r_vid_valid)  r_vid_data  <= bus.ram_dout;
            if (bus.ldr_wr && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    // Read data is passed straight through during the valid clk, then held in the capture register.
    assign bus.cpu_rdata    = r_cpu_rvalid ? bus.ram_dout : r_cpu_rdata;
    assign bus.vid_data     = r_vid_valid  ? bus.ram_dout : r_vid_data;
    assign bus.cpu_rvalid   = r_cpu_rvalid;
    assign bus.vid_valid    = r_vid_valid;
    assign bus.ldr_ready    = (w_count != ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
    assign bus.ldr_overflow = r_overflow;
    assign bus.ram_en       = r_ram_en;
    assign bus.ram_we       = r_ram_we;
    assign bus.ram_addr     = r_ram_addr;
    assign bus.ram_din      = r_ram_din;
endmodule
